// File: rtl/inst_loader.sv
// Boot loader: assembles little-endian words from a UART byte stream, writes them into
// instruction memory one 32-bit slot at a time, holds the core while loading, then acks.
module inst_loader #(
    parameter int          MAX_WORDS = 65536,
    parameter logic [4:0]  PREFIX    = 5'b11110,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        wr_ready,
    output logic [31:0] dec_op32,
    output logic [29:0] daddr3,
    output logic        dec_mwe3,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_ACK, S_DONE} state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_buf;
    logic [16:0] len;
    logic [16:0] widx;

    logic        rx_active, word_done, pending, accept, want, load, overrun, last_acc;
    logic [31:0] word;

    assign rx_active = (state == S_LEN) || (state == S_DATA);
    assign word_done = rx_valid && (byte_cnt == 2'd3) && rx_active;
    assign word      = {rx_data, asm_buf};
    assign pending   = dec_mwe3 && !wr_ready;
    assign accept    = dec_mwe3 && wr_ready;
    // Words beyond the announced count are dropped rather than written.
    assign want      = word_done && (state == S_DATA) && (widx < len);
    assign load      = want && !pending;
    assign overrun   = want && pending;
    // The pending word's index is recovered from its row/slot address bits.
    assign last_acc  = accept && ({1'b0, daddr3[15:0]} == (len - 17'd1));

    assign tx_valid  = (state == S_ACK);
    assign tx_data   = tx_valid ? ACK_BYTE : 8'h00;
    assign core_hold = (state == S_LEN) || (state == S_DATA) || (state == S_ACK);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_LEN;
            S_LEN: begin
                if (word_done) begin
                    if (word == 32'd0)      state_next = S_ACK;
                    else if (word > MAX_W)  state_next = S_IDLE;
                    else                    state_next = S_DATA;
                end
            end
            S_DATA: if (last_acc) state_next = S_ACK;
            S_ACK:  if (tx_ready) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            asm_buf  <= 24'd0;
            len      <= 17'd0;
            widx     <= 17'd0;
            dec_op32 <= 32'd0;
            daddr3   <= 30'd0;
            dec_mwe3 <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == S_IDLE || state == S_DONE) && start) begin
                byte_cnt <= 2'd0;
                len      <= 17'd0;
                widx     <= 17'd0;
                err      <= 1'b0;
            end else if (rx_valid && rx_active) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_buf[7:0]   <= rx_data;
                    2'd1:    asm_buf[15:8]  <= rx_data;
                    2'd2:    asm_buf[23:16] <= rx_data;
                    default: ;
                endcase
            end
            if (state == S_LEN && word_done) begin
                if (word > MAX_W) err <= 1'b1;
                else              len <= word[16:0];
            end
            if (overrun) err <= 1'b1;
            if (load) begin
                dec_op32 <= word;
                daddr3   <= {PREFIX, 9'd0, widx[15:0]};
                dec_mwe3 <= 1'b1;
                widx     <= widx + 17'd1;
            end else if (accept) begin
                dec_mwe3 <= 1'b0;
            end
            if (state == S_ACK && tx_ready) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: loads, stalls, overrun, length edge cases, mid-load reset.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid, wr_ready, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] dec_op32;
    logic [29:0] daddr3;
    logic        dec_mwe3, tx_valid, core_hold, done, err;

    int pass_cnt = 0;
    int total    = 0;
    logic [29:0] wa[$];
    logic [31:0] wd[$];
    bit mwe_seen;

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_ready(wr_ready), .dec_op32(dec_op32), .daddr3(daddr3), .dec_mwe3(dec_mwe3),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && dec_mwe3) mwe_seen = 1'b1;
        if (!rst && dec_mwe3 && wr_ready) begin
            wa.push_back(daddr3);
            wd.push_back(dec_op32);
        end
    end

    // All drivers run at posedge+1 and return at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        @(negedge clk);
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hAA)
            $display("FAIL %s_ack: tx_valid=%b tx_data=%h, required 1/aa", name, tx_valid, tx_data);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || core_hold !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL %s_done: done=%b hold=%b tx_valid=%b, required 1/0/0", name, done, core_hold, tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({dec_op32, daddr3, dec_mwe3, tx_valid, tx_data, core_hold, done, err} !== 76'd0)
            $display("FAIL reset: op=%h addr=%h mwe=%b txv=%b txd=%h hold=%b done=%b err=%b, required all 0",
                     dec_op32, daddr3, dec_mwe3, tx_valid, tx_data, core_hold, done, err);
        else pass_cnt++;
    endtask

    task automatic test_basic_load();
        logic [31:0] w[3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        logic [29:0] a[3] = '{30'h3C000000, 30'h3C000001, 30'h3C000002};
        int base = wa.size();
        pulse_start();
        total++;
        if (core_hold !== 1'b1) $display("FAIL hold_in_len: got %b required 1", core_hold);
        else pass_cnt++;
        send_word(32'd3);
        send_word(w[0]);
        total++;
        if (dec_mwe3 !== 1'b1 || daddr3 !== a[0] || dec_op32 !== w[0])
            $display("FAIL first_write_latency: mwe=%b addr=%h op=%h, required 1/%h/%h", dec_mwe3, daddr3, dec_op32, a[0], w[0]);
        else pass_cnt++;
        send_word(w[1]);
        send_word(w[2]);
        wait_ack("basic");
        total++;
        if (wa.size() - base != 3) $display("FAIL basic_count: got %0d required 3", wa.size() - base);
        else pass_cnt++;
        for (int i = 0; i < 3 && base + i < wa.size(); i++) begin
            total++;
            if (wa[base+i] !== a[i] || wd[base+i] !== w[i])
                $display("FAIL basic_write%0d: addr=%h op=%h, required %h/%h", i, wa[base+i], wd[base+i], a[i], w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_row_slot();
        int base = wa.size();
        pulse_start();
        send_word(32'd5);
        for (int i = 0; i < 4; i++) send_word(32'h1000 + i);
        send_word(32'hDEADBEEF);
        wait_ack("rowslot");
        total++;
        if (wa.size() - base != 5 || wa[base+4] !== 30'h3C000004 || wd[base+4] !== 32'hDEADBEEF)
            $display("FAIL row1_slot0: n=%0d addr=%h op=%h, required 5/3c000004/deadbeef",
                     wa.size() - base, wa[wa.size()-1], wd[wd.size()-1]);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int base = wa.size();
        bit stable = 1'b1;
        pulse_start();
        send_word(32'd2);
        wr_ready = 1'b0;
        send_word(32'hCAFEF00D);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dec_mwe3 !== 1'b1 || dec_op32 !== 32'hCAFEF00D || daddr3 !== 30'h3C000000) stable = 1'b0;
        end
        total++;
        if (!stable) $display("FAIL stall_hold: mwe=%b op=%h addr=%h, required 1/cafef00d/3c000000", dec_mwe3, dec_op32, daddr3);
        else pass_cnt++;
        @(posedge clk); #1;
        wr_ready = 1'b1;
        send_word(32'h0BADC0DE);
        wait_ack("stall");
        total++;
        if (wa.size() - base != 2 || err !== 1'b0 || wd[base+1] !== 32'h0BADC0DE)
            $display("FAIL stall_writes: n=%0d err=%b, required 2/0", wa.size() - base, err);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int base = wa.size();
        pulse_start();
        send_word(32'd2);
        wr_ready = 1'b0;
        send_word(32'hAAAA0000);
        send_word(32'hBBBB1111);
        total++;
        if (err !== 1'b1 || dec_op32 !== 32'hAAAA0000 || dec_mwe3 !== 1'b1)
            $display("FAIL overrun_err: err=%b op=%h mwe=%b, required 1/aaaa0000/1", err, dec_op32, dec_mwe3);
        else pass_cnt++;
        wr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (wa.size() - base != 1 || wd[base] !== 32'hAAAA0000 || dec_mwe3 !== 1'b0 || err !== 1'b1)
            $display("FAIL overrun_writes: n=%0d mwe=%b err=%b, required 1/0/1", wa.size() - base, dec_mwe3, err);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_length_edges();
        int base = wa.size();
        mwe_seen = 1'b0;
        pulse_start();
        send_word(32'd0);
        wait_ack("zero");
        total++;
        if (mwe_seen || wa.size() != base) $display("FAIL zero_len_writes: mwe_seen=%b n=%0d, required 0/0", mwe_seen, wa.size() - base);
        else pass_cnt++;
        pulse_start();
        send_word(32'd70000);
        total++;
        if (err !== 1'b1 || core_hold !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL too_long: err=%b hold=%b txv=%b, required 1/0/0", err, core_hold, tx_valid);
        else pass_cnt++;
        pulse_start();
        total++;
        if (err !== 1'b0 || core_hold !== 1'b1) $display("FAIL start_clears_err: err=%b hold=%b, required 0/1", err, core_hold);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_mid_reset();
        int base;
        pulse_start();
        send_word(32'd4);
        send_word(32'h01020304);
        send_word(32'h05060708);
        do_reset();
        total++;
        if ({dec_op32, daddr3, dec_mwe3, tx_valid, tx_data, core_hold, done, err} !== 76'd0)
            $display("FAIL mid_reset: op=%h addr=%h mwe=%b hold=%b err=%b, required all 0",
                     dec_op32, daddr3, dec_mwe3, core_hold, err);
        else pass_cnt++;
        base = wa.size();
        pulse_start();
        send_word(32'd4);
        for (int i = 0; i < 4; i++) send_word(32'hF0000000 | i);
        wait_ack("reload");
        total++;
        if (wa.size() - base != 4 || wa[base+3] !== 30'h3C000003 || wd[base+3] !== 32'hF0000003)
            $display("FAIL reload: n=%0d, required 4 writes ending 3c000003/f0000003", wa.size() - base);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        wr_ready = 1'b1; tx_ready = 1'b1; mwe_seen = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic_load();
        test_row_slot();
        test_stall();
        test_overrun();
        test_length_edges();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
